// File: rtl/leon_dcache_responder.sv
// leon_dcache_responder: wait-stated data-cache responder for the LEON IU,
// backed by a word RAM with per-word valid shadow (unwritten words read INIT_WORD).
// Ports: clk, rst (async active-low); req_valid/req_read/req_addr/req_size/req_edata in;
// dco_data/dco_hold/dco_mds/dco_mexc/dco_werr/busy out.
// Optional LEON_DCRESP_STATS_EN adds stat_loads/stat_stores/stat_errs counters.
module leon_dcache_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_edata,
  output logic [31:0] dco_data,
  output logic        dco_hold,
  output logic        dco_mds,
  output logic        dco_mexc,
  output logic        dco_werr,
  output logic        busy
`ifdef LEON_DCRESP_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WLAST =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_BEAT, S_ERR
  } state_t;

  state_t state, nxt;

  logic          rd;
  logic [31:0]   addr;
  logic [1:0]    size;
  logic [31:0]   edata;
  logic          second;
  logic [CW-1:0] cnt;

  logic [31:0]        mem [MEM_WORDS];
  logic [MEM_WORDS-1:0] vld;

  logic [31:0] off_in, off_q, rword, mask, wdat, merged, ld;
  logic [AW-1:0] idx;
  logic [4:0]  sh;
  logic        rng_ok, aln_ok, more, done;
  logic        unused;

  assign off_in = req_addr - BASE_ADDR;
  assign off_q  = addr - BASE_ADDR;
  assign idx    = off_q[AW+1:2];
  assign unused = ^{off_q[31:AW+2], off_q[1:0]};
  assign rword  = vld[idx] ? mem[idx] : INIT_WORD;

  // Doubleword must fit both words; aligned offsets make this exact.
  assign rng_ok = (req_size == 2'b11) ? (off_in < SPAN - 32'd4)
                                      : (off_in < SPAN);

  always_comb begin
    aln_ok = 1'b1;
    unique case (req_size)
      2'b01:   aln_ok = ~req_addr[0];
      2'b10:   aln_ok = req_addr[1:0] == 2'b00;
      2'b11:   aln_ok = req_addr[2:0] == 3'b000;
      default: aln_ok = 1'b1;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    sh   = 5'd0;
    mask = 32'hFFFF_FFFF;
    wdat = edata;
    unique case (size)
      2'b00: begin
        sh   = {~addr[1:0], 3'b000};
        mask = 32'h0000_00FF << sh;
        wdat = {24'h0, edata[7:0]} << sh;
      end
      2'b01: begin
        sh   = addr[1] ? 5'd0 : 5'd16;
        mask = 32'h0000_FFFF << sh;
        wdat = {16'h0, edata[15:0]} << sh;
      end
      default: begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        wdat = edata;
      end
    endcase
  end

  assign merged = (rword & ~mask) | (wdat & mask);
  assign ld     = (rword & mask) >> sh;
  assign more   = (size == 2'b11) && !second;
  assign done   = (state == S_BEAT) && !more;

  always_comb begin
    nxt      = state;
    dco_data = 32'h0;
    dco_hold = 1'b1;
    dco_mds  = 1'b0;
    dco_mexc = 1'b0;
    dco_werr = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!(rng_ok && aln_ok)) nxt = S_ERR;
          else if (WAIT_CYCLES > 0) nxt = S_WAIT;
          else nxt = S_BEAT;
        end
      end
      S_WAIT: begin
        dco_hold = 1'b0;
        if (cnt == WLAST) nxt = S_BEAT;
      end
      S_BEAT: begin
        if (rd) begin
          dco_data = ld;
          dco_mds  = 1'b1;
        end
        if (!more) nxt = S_IDLE;
        else if (WAIT_CYCLES > 0) nxt = S_WAIT;
        else nxt = S_BEAT;
      end
      S_ERR: begin
        dco_mexc = rd;
        dco_werr = ~rd;
        nxt      = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy = state != S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      rd     <= 1'b0;
      addr   <= 32'h0;
      size   <= 2'b00;
      edata  <= 32'h0;
      second <= 1'b0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            rd     <= req_read;
            addr   <= req_addr;
            size   <= req_size;
            edata  <= req_edata;
            second <= 1'b0;
            cnt    <= '0;
          end
        end
        S_WAIT: cnt <= (cnt == WLAST) ? '0 : cnt + 1'b1;
        S_BEAT: begin
          if (!rd) vld[idx] <= 1'b1;
          if (more) begin
            addr   <= addr + 32'd4;
            second <= 1'b1;
            if (!rd) edata <= req_edata;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM array itself is never reset; the valid shadow masks stale words.
  always_ff @(posedge clk) begin
    if (state == S_BEAT && !rd) mem[idx] <= merged;
  end

`ifdef LEON_DCRESP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= 16'h0;
      stat_stores <= 16'h0;
      stat_errs   <= 16'h0;
    end else begin
      if (done && rd && stat_loads != 16'hFFFF)
        stat_loads <= stat_loads + 16'd1;
      if (done && !rd && stat_stores != 16'hFFFF)
        stat_stores <= stat_stores + 16'd1;
      if (state == S_ERR && stat_errs != 16'hFFFF)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_leon_dcache_responder.sv
// tb_leon_dcache_responder: directed bench, one instance with 2 wait states
// and one with 0 wait states sharing the same request inputs.
module tb_leon_dcache_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_read  = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [1:0]  req_size  = 2'b00;
  logic [31:0] req_edata = 32'h0;

  logic [31:0] data, z_data;
  logic hold, mds, mexc, werr, busy;
  logic z_hold, z_mds, z_mexc, z_werr, z_busy;
`ifdef LEON_DCRESP_STATS_EN
  logic [15:0] s_ld, s_st, s_er, zs_ld, zs_st, zs_er;
`endif

  leon_dcache_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read),
    .req_addr(req_addr), .req_size(req_size),
    .req_edata(req_edata),
    .dco_data(data), .dco_hold(hold), .dco_mds(mds),
    .dco_mexc(mexc), .dco_werr(werr), .busy(busy)
`ifdef LEON_DCRESP_STATS_EN
    , .stat_loads(s_ld), .stat_stores(s_st), .stat_errs(s_er)
`endif
  );

  leon_dcache_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read),
    .req_addr(req_addr), .req_size(req_size),
    .req_edata(req_edata),
    .dco_data(z_data), .dco_hold(z_hold), .dco_mds(z_mds),
    .dco_mexc(z_mexc), .dco_werr(z_werr), .busy(z_busy)
`ifdef LEON_DCRESP_STATS_EN
    , .stat_loads(zs_ld), .stat_stores(zs_st), .stat_errs(zs_er)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic access(input logic rd, input logic [31:0] a,
                        input logic [1:0] sz,
                        input logic [31:0] e0, input logic [31:0] e1,
                        output logic [31:0] d0, output logic [31:0] d1,
                        output int stall, output int nmds,
                        output int nmexc, output int nwerr);
    int cyc;
    d0 = 32'h0; d1 = 32'h0;
    stall = 0; nmds = 0; nmexc = 0; nwerr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_read = rd;
    req_addr = a; req_size = sz; req_edata = e0;
    @(negedge clk);
    req_valid = 1'b0; req_edata = e1;
    cyc = 0;
    while (busy && cyc < 20) begin
      if (!hold) stall++;
      if (mds) begin
        if (nmds == 0) d0 = data;
        else d1 = data;
        nmds++;
      end
      if (mexc) nmexc++;
      if (werr) nwerr++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) check("timeout", {31'h0, busy}, 32'h0);
  endtask

  logic [31:0] d0, d1;
  int st, nm, nx, nw;

  initial begin
    #12;
    check("rst_hold", {31'h0, hold}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_mds",  {31'h0, mds}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    access(0, 32'h4000_0010, 2'b10, 32'hDEAD_BEEF, 0, d0, d1, st, nm, nx, nw);
    check("st_stall", st, 2);
    check("st_werr", nw, 0);
    access(1, 32'h4000_0010, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("ld_data", d0, 32'hDEAD_BEEF);
    check("ld_mds", nm, 1);
    check("ld_stall", st, 2);

    access(0, 32'h4000_0021, 2'b00, 32'h0000_00AB, 0, d0, d1, st, nm, nx, nw);
    access(1, 32'h4000_0020, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("byte_word", d0, 32'h00AB_0000);
    access(1, 32'h4000_0022, 2'b01, 0, 0, d0, d1, st, nm, nx, nw);
    check("half_hi", d0, 32'h0);
    access(1, 32'h4000_0020, 2'b01, 0, 0, d0, d1, st, nm, nx, nw);
    check("half_lo", d0, 32'h0000_00AB);
    access(1, 32'h4000_0021, 2'b00, 0, 0, d0, d1, st, nm, nx, nw);
    check("byte_ld", d0, 32'h0000_00AB);

    access(0, 32'h4000_0008, 2'b11, 32'h1111_1111, 32'h2222_2222,
           d0, d1, st, nm, nx, nw);
    check("dst_stall", st, 4);
    access(1, 32'h4000_0008, 2'b11, 0, 0, d0, d1, st, nm, nx, nw);
    check("dld_d0", d0, 32'h1111_1111);
    check("dld_d1", d1, 32'h2222_2222);
    check("dld_mds", nm, 2);
    check("dld_stall", st, 4);
    access(1, 32'h4000_000C, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("odd_word", d0, 32'h2222_2222);

    access(1, 32'h3FFF_FFFC, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("lo_mexc", nx, 1);
    check("lo_mds", nm, 0);
    access(0, 32'h4000_0002, 2'b10, 32'h5555_5555, 0, d0, d1, st, nm, nx, nw);
    check("mis_werr", nw, 1);
    access(1, 32'h4000_0000, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("mis_unch", d0, 32'h0);
    access(1, 32'h4000_0FFC, 2'b11, 0, 0, d0, d1, st, nm, nx, nw);
    check("dlast_mexc", nx, 1);
    access(1, 32'h4000_0FF8, 2'b11, 0, 0, d0, d1, st, nm, nx, nw);
    check("dtop_ok", nx, 0);
    check("dtop_mds", nm, 2);
    access(1, 32'h4000_1000, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("end_mexc", nx, 1);
    access(0, 32'h4000_0011, 2'b01, 32'h1234, 0, d0, d1, st, nm, nx, nw);
    check("half_werr", nw, 1);

    access(0, 32'h4000_0100, 2'b10, 32'hCAFE_F00D, 0, d0, d1, st, nm, nx, nw);
    access(1, 32'h4000_0100, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("pre_rst", d0, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1;
    req_addr = 32'h4000_0100; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_hold", {31'h0, hold}, 32'h0);
    rst = 1'b0;
    #1;
    check("ar_hold", {31'h0, hold}, 32'h1);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_data", data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    access(1, 32'h4000_0100, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("post_rst", d0, 32'h0);
    access(1, 32'h4000_0010, 2'b10, 0, 0, d0, d1, st, nm, nx, nw);
    check("post_rst2", d0, 32'h0);

    access(0, 32'h4000_0040, 2'b10, 32'h1357_2468, 0, d0, d1, st, nm, nx, nw);
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1;
    req_addr = 32'h4000_0040; req_size = 2'b10;
    nm = 0; st = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!z_hold) st++;
      if (z_mds) begin
        nm++;
        check("z_data", z_data, 32'h1357_2468);
      end
    end
    req_valid = 1'b0;
    check("z_mds_cnt", nm, 3);
    check("z_no_stall", st, 0);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("drain", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/leon_dcache_responder.md
Name: leon_dcache_responder

Overview:
- Synthesizable data-cache-side responder for the LEON integer unit (IU).
- Accepts IU data requests (address, read/write, size, store data) and returns load data, hold, memory exception and write error signals.
- Backed by an internal word-addressed RAM.
- Replaces static bench driving of the dcache output record with a cycle-accurate memory model that has wait states, so the IU pipeline sees realistic stalls.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h40000000: byte address of RAM word 0.
- WAIT_CYCLES, 2: stall cycles inserted before each beat completes. 0 means a single-cycle response.
- INIT_WORD, 32'h00000000: value returned by RAM words never written since reset.

Ports:
- clk  input  1  core clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  IU presents a data access this cycle (sampled only in IDLE)
- req_read  input  1  1 = load, 0 = store
- req_addr  input  32  byte address
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 doubleword
- req_edata  input  32  store data, right-justified; for doubleword, first the even word, then the odd word
- dco_data  output  32  load data, right-justified, zero-extended (IU sign-extends)
- dco_hold  output  1  active-low stall; 0 = IU must freeze, 1 = beat complete or idle
- dco_mds  output  1  1-cycle pulse with each valid load beat
- dco_mexc  output  1  1-cycle pulse: load exception (range or alignment)
- dco_werr  output  1  1-cycle pulse: store error (range or alignment)
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, dco_data=0, dco_hold=1, dco_mds=0, dco_mexc=0, dco_werr=0, busy=0, wait counter=0.
- RAM contents are not reset. A shadow valid bit per word clears on reset, and unwritten words read as INIT_WORD.
- Reset asserted mid-access aborts the access. A partial store already committed stays committed; nothing else is written.
- States: IDLE, WAIT, BEAT, ERR.
- IDLE:
  - On req_valid, latch read, addr, size and edata.
  - Check range: addr - BASE_ADDR < MEM_WORDS*4.
  - Check alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
  - Any violation -> ERR. Otherwise -> WAIT if WAIT_CYCLES>0, else BEAT.
  - dco_hold drops to 0 in the cycle after req_valid is sampled.
- WAIT: count WAIT_CYCLES cycles with dco_hold=0, then go to BEAT.
- BEAT (one cycle, dco_hold=1):
  - Load: dco_data holds the selected lanes; dco_mds=1.
  - Store: byte-lane merge into the RAM word using big-endian SPARC lane order. addr[1:0]=00 selects bits [31:24].
  - Single-beat access -> IDLE.
  - Doubleword, first beat:
    - Increment the latched addr by 4.
    - For a store, req_edata is re-sampled in this BEAT cycle as the odd word.
    - Return to WAIT (or BEAT directly if WAIT_CYCLES=0) for the second beat, then go to IDLE.
- ERR (one cycle, dco_hold=1):
  - dco_mexc=1 for a load, dco_werr=1 for a store.
  - No RAM write. dco_data=0. Then go to IDLE.
- Latency per beat: WAIT_CYCLES+1 cycles from sample to completion. A doubleword takes 2*(WAIT_CYCLES+1).
- A new req_valid may be sampled in the cycle after BEAT or ERR returns to IDLE. req_valid outside IDLE is ignored.
- Doubleword range check covers both words, so the last word of RAM plus 4 -> ERR.
- Address wrap: the range check uses 32-bit unsigned subtraction, so an addr below BASE_ADDR wraps large and errors.

Optional Feature:
- Macro: LEON_DCRESP_STATS_EN.
- Defined:
  - Adds outputs stat_loads[15:0], stat_stores[15:0] and stat_errs[15:0].
  - Each counts completed single accesses (a doubleword counts once), or ERR visits.
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word store then load, WAIT_CYCLES=2:
  - Stimulus: store 32'hDEADBEEF at 0x40000010, then load 0x40000010.
  - Response: dco_hold=0 for exactly 2 cycles per access; load returns dco_data=32'hDEADBEEF with dco_mds=1 for one cycle.
- Byte and half lanes:
  - Stimulus: store byte 8'hAB at 0x40000021, then load the word at 0x40000020.
  - Response: 32'h00AB0000; unwritten lanes read from INIT_WORD=0.
  - Stimulus: halfword load at 0x40000022.
  - Response: 32'h00000000.
- Doubleword:
  - Stimulus: store 32'h11111111 / 32'h22222222 at 0x40000008, then doubleword load.
  - Response: two dco_mds pulses with data 32'h11111111 then 32'h22222222; total stall 4 cycles.
- Errors:
  - Load at 0x3FFFFFFC -> dco_mexc pulse and no dco_mds.
  - Word store at 0x40000002 -> dco_werr pulse and RAM unchanged.
  - Doubleword at the last RAM word -> ERR.
- Reset mid-access:
  - Stimulus: assert rst during WAIT of a load.
  - Response: all outputs immediately return to reset values; the next load of a never-written word returns INIT_WORD.
- Zero wait states, WAIT_CYCLES=0:
  - Stimulus: back-to-back word loads.
  - Response: dco_hold=1 throughout; one beat per 2 cycles (sample, then BEAT).
